// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//   Turns an ALU compare result into a PC-select decision. The decision is
//   also registered once, and conditional-taken and jump events are counted.
//
// Ports
//   clk         : rising-edge clock for all registered state
//   rst_n       : asynchronous active-low reset
//   alu_result  : SUB difference (EQ/NE) or SLT/SLTU result (LT/GE/LTU/GEU)
//   cmp_opcode  : compare selector
//                 EQ=000 NE=001 LT=100 GE=101 LTU=110 GEU=111
//                 010/011 = no compare
//   pc_jump     : unconditional jump (JAL/JALR)
//   branch      : combinational PC select
//                 00 = PC+4, 01 = conditional branch taken, 10 = jump
//   branch_q    : branch registered once
//   taken_cnt   : count of edges at which branch == 01 (wraps)
//   jump_cnt    : count of edges at which branch == 10 (wraps)
// -----------------------------------------------------------------------------
module branch_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      alu_result,
  input  logic [2:0]       cmp_opcode,
  input  logic             pc_jump,
  output logic [1:0]       branch,
  output logic [1:0]       branch_q,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] jump_cnt
);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_GE  = 3'b101;
  localparam logic [2:0] OP_LTU = 3'b110;
  localparam logic [2:0] OP_GEU = 3'b111;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_TAKE = 2'b01;
  localparam logic [1:0] SEL_JUMP = 2'b10;

  logic             cond_s;
  logic [1:0]       branch_s;
  logic [1:0]       branch_q_r;
  logic [CNT_W-1:0] taken_cnt_r;
  logic [CNT_W-1:0] jump_cnt_r;

  // Evaluate the compare condition. The SLT/SLTU result lives in bit 0
  // only, so the upper bits are ignored for the ordered compares.
  // Unknown opcodes fall to the default and give false.
  function automatic logic cond_eval(input logic [2:0]  op,
                                     input logic [31:0] res);
    logic c;
    c = 1'b0;
    case (op)
      OP_EQ:   c = (res == 32'd0);
      OP_NE:   c = (res != 32'd0);
      OP_LT,
      OP_LTU:  c = (res[0] == 1'b1);
      OP_GE,
      OP_GEU:  c = (res[0] == 1'b0);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // Compute the compare condition from the current inputs.
  always_comb begin
    cond_s = cond_eval(cmp_opcode, alu_result);
  end

  // Select the PC source. Only a known 1 on pc_jump selects a jump.
  // The taken path also requires a known 0 on pc_jump. An X/Z compare
  // evaluates as not-true in the if, so unknown inputs fall to PC+4.
  always_comb begin
    branch_s = SEL_SEQ;
    if (pc_jump == 1'b1) begin
      branch_s = SEL_JUMP;
    end else if ((pc_jump == 1'b0) && cond_s) begin
      branch_s = SEL_TAKE;
    end else begin
      branch_s = SEL_SEQ;
    end
  end

  // Register the decision once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q_r <= 2'b00;
    end else begin
      branch_q_r <= branch_s;
    end
  end

  // Count events. The two counters are mutually exclusive by the branch
  // encoding, and each wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_r <= '0;
      jump_cnt_r  <= '0;
    end else begin
      case (branch_s)
        SEL_TAKE: taken_cnt_r <= taken_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        SEL_JUMP: jump_cnt_r  <= jump_cnt_r  + {{(CNT_W-1){1'b0}}, 1'b1};
        default: begin
          taken_cnt_r <= taken_cnt_r;
          jump_cnt_r  <= jump_cnt_r;
        end
      endcase
    end
  end

  assign branch    = branch_s;
  assign branch_q  = branch_q_r;
  assign taken_cnt = taken_cnt_r;
  assign jump_cnt  = jump_cnt_r;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//   Directed self-checking bench for branch_unit. It instantiates one DUT at
//   the default counter width and one at CNT_W = 4 (for counter wrap). Both
//   DUTs share the same inputs.
// -----------------------------------------------------------------------------
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result;
  logic [2:0]  cmp_opcode;
  logic        pc_jump;

  logic [1:0]  branch_w,   branch_q_w;
  logic [31:0] taken_w,    jump_w;
  logic [1:0]  branch_n,   branch_q_n;
  logic [3:0]  taken_n,    jump_n;

  int checks_r = 0;
  int errors_r = 0;

  branch_unit dut_w (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_result (alu_result),
    .cmp_opcode (cmp_opcode),
    .pc_jump    (pc_jump),
    .branch     (branch_w),
    .branch_q   (branch_q_w),
    .taken_cnt  (taken_w),
    .jump_cnt   (jump_w)
  );

  branch_unit #(.CNT_W(4)) dut_n (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_result (alu_result),
    .cmp_opcode (cmp_opcode),
    .pc_jump    (pc_jump),
    .branch     (branch_n),
    .branch_q   (branch_q_n),
    .taken_cnt  (taken_n),
    .jump_cnt   (jump_n)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] res,
                       input logic jmp);
    cmp_opcode = op;
    alu_result = res;
    pc_jump    = jmp;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    logic        jmp;
    logic [1:0]  exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{3'b000, 32'h0000_0000, 1'b0, 2'b01};
    vecs[1]  = '{3'b000, 32'h0000_0001, 1'b0, 2'b00};
    vecs[2]  = '{3'b001, 32'h0000_0001, 1'b0, 2'b01};
    vecs[3]  = '{3'b001, 32'h0000_0000, 1'b0, 2'b00};
    vecs[4]  = '{3'b100, 32'h0000_0001, 1'b0, 2'b01};
    vecs[5]  = '{3'b100, 32'hFFFF_FFFE, 1'b0, 2'b00};
    vecs[6]  = '{3'b101, 32'h0000_0000, 1'b0, 2'b01};
    vecs[7]  = '{3'b101, 32'hFFFF_FFFE, 1'b0, 2'b01};
    vecs[8]  = '{3'b110, 32'h0000_0001, 1'b0, 2'b01};
    vecs[9]  = '{3'b111, 32'h0000_0000, 1'b0, 2'b01};
    vecs[10] = '{3'b111, 32'h0000_0001, 1'b0, 2'b00};
    vecs[11] = '{3'b000, 32'h0000_0000, 1'b1, 2'b10};
    vecs[12] = '{3'b010, 32'h0000_0000, 1'b0, 2'b00};
    vecs[13] = '{3'b011, 32'h0000_0000, 1'b0, 2'b00};
    vecs[14] = '{3'b011, 32'h0000_0000, 1'b1, 2'b10};
    vecs[15] = '{3'b001, 32'h8000_0000, 1'b0, 2'b01};
  end

  initial begin
    rst_n = 1'b0;
    drive(3'b010, 32'd0, 1'b0);
    #12;
    check("rst_branch_q", {62'd0, branch_q_w}, 64'd0);
    check("rst_taken",    {32'd0, taken_w},    64'd0);
    check("rst_jump",     {32'd0, jump_w},     64'd0);

    // Combinational decode while still in reset.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].op, vecs[i].res, vecs[i].jmp);
      #1;
      check($sformatf("comb_vec%0d", i), {62'd0, branch_w}, {62'd0, vecs[i].exp});
    end
    check("rst_hold_taken", {32'd0, taken_w}, 64'd0);

    // Release reset away from the edge with a no-compare input.
    @(negedge clk);
    drive(3'b010, 32'd0, 1'b0);
    rst_n = 1'b1;

    // Sequence 01, 01, 10, 00.
    drive(3'b000, 32'd0, 1'b0);
    @(posedge clk); #1;
    check("seq1_bq",    {62'd0, branch_q_w}, 64'd1);
    check("seq1_taken", {32'd0, taken_w},    64'd1);
    check("seq1_jump",  {32'd0, jump_w},     64'd0);
    @(negedge clk); drive(3'b001, 32'd1, 1'b0);
    @(posedge clk); #1;
    check("seq2_bq",    {62'd0, branch_q_w}, 64'd1);
    check("seq2_taken", {32'd0, taken_w},    64'd2);
    @(negedge clk); drive(3'b000, 32'd5, 1'b1);
    @(posedge clk); #1;
    check("seq3_bq",    {62'd0, branch_q_w}, 64'd2);
    check("seq3_jump",  {32'd0, jump_w},     64'd1);
    check("seq3_taken", {32'd0, taken_w},    64'd2);
    @(negedge clk); drive(3'b011, 32'd0, 1'b0);
    @(posedge clk); #1;
    check("seq4_bq",    {62'd0, branch_q_w}, 64'd0);
    check("seq4_taken", {32'd0, taken_w},    64'd2);
    check("seq4_jump",  {32'd0, jump_w},     64'd1);
    check("seq4_taken4",{60'd0, taken_n},    64'd2);

    // Drive 13 more taken edges so the narrow counter reaches 15.
    @(negedge clk); drive(3'b111, 32'd0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
    end
    #1;
    check("pre_wrap_taken4", {60'd0, taken_n}, 64'd15);
    @(posedge clk); #1;
    check("wrap_taken4",  {60'd0, taken_n}, 64'd0);
    check("wrap_jump4",   {60'd0, jump_n},  64'd1);
    check("wrap_taken32", {32'd0, taken_w}, 64'd16);

    // Assert reset mid-cycle: clears without an edge, and branch stays live.
    @(negedge clk); drive(3'b000, 32'd0, 1'b1);
    @(posedge clk); #2;
    check("pre_rst_jump", {32'd0, jump_w}, 64'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bq",    {62'd0, branch_q_w}, 64'd0);
    check("mid_rst_taken", {32'd0, taken_w},    64'd0);
    check("mid_rst_jump",  {32'd0, jump_w},     64'd0);
    check("mid_rst_jump4", {60'd0, jump_n},     64'd0);
    drive(3'b100, 32'd1, 1'b0);
    #1;
    check("mid_rst_branch", {62'd0, branch_w}, 64'd1);

    // First edge after release captures normally.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_bq",    {62'd0, branch_q_w}, 64'd1);
    check("post_rst_taken", {32'd0, taken_w},    64'd1);
    check("post_rst_jump",  {32'd0, jump_w},     64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_r, errors_r);
    $finish;
  end

endmodule
